floating_point_unit_scheduler: RTL
==================================

Name: floating_point_unit_scheduler

Overview:
- Issue and writeback scheduler for the single-precision FPU.
- Accepts one FP operation per cycle and starts the selected sub-unit: adder, multiplier, converter, comparator (all fixed latency) or divider/sqrt (iterative, variable latency).
- Reserves the single shared result-bus slot so that no two units write back in the same cycle, and returns the instruction tag with each result.
- Sits between the FP issue stage and the FP sub-units and result mux.

Parameters:
- TAG_W, 6, width of the instruction tag carried with each operation.
- ADD_LAT, 3, adder cycles from start to result (at least 1).
- MUL_LAT, 4, multiplier cycles from start to result (at least 1).
- CVT_LAT, 2, converter cycles from start to result (at least 1).
- CMP_LAT, 1, compare/classify cycles from start to result (at least 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  kill all in-flight operations.
- issue_valid_i  in  1  operation offered.
- issue_unit_i  in  3  target unit, type fpu_unit_t.
- issue_tag_i  in  TAG_W  instruction tag.
- issue_ready_o  out  1  operation accepted this cycle when issue_valid_i is also high.
- unit_start_o  out  5  one-hot start pulse, indexed by fpu_unit_t.
- div_done_i  in  1  divider result available; held until acknowledged.
- div_ack_o  out  1  divider result taken this cycle.
- div_kill_o  out  1  abort the divider.
- wb_valid_o  out  1  result valid on the shared bus this cycle.
- wb_unit_o  out  3  unit to select in the result mux.
- wb_tag_o  out  TAG_W  tag of the result being written back.

Behaviour:
- Reservation table: slot[0..MAX_LAT-1], where MAX_LAT is the maximum of the four fixed latencies. Each slot holds {valid, unit, tag}.
- Every cycle the table shifts: slot[i] takes slot[i+1], and slot[MAX_LAT-1] clears.
- Fixed-latency issue with latency L:
  - Free when L = MAX_LAT, or when slot[L] is currently not valid.
  - On accept, slot[L-1] is written in the same update as the shift.
  - The result appears on wb_* exactly L cycles after the accept cycle.
- Divider issue: free when div_busy = 0. On accept, div_busy is set. div_busy clears on the cycle div_ack_o is high.
- issue_ready_o is combinational. It is 1 only when all of these hold:
  - issue_unit_i is free;
  - no flush_i;
  - div_done_i is low or div_ack_o is high this cycle.
- issue_ready_o may depend on issue_unit_i; the issuer must not change the payload while waiting.
- Undefined unit codes (5-7): issue_ready_o = 0.
- unit_start_o: bit issue_unit_i is high in the accept cycle; all bits are 0 otherwise.
- Writeback when slot[0].valid = 1:
  - wb_valid_o = 1, wb_unit_o = slot[0].unit, wb_tag_o = slot[0].tag.
- Writeback when slot[0].valid = 0 and div_done_i = 1:
  - wb_valid_o = 1, wb_unit_o = DIV, wb_tag_o = stored divider tag, div_ack_o = 1.
- Fixed-latency results always take priority over the divider.
- Starvation guard: while the divider result is pending, new issues are blocked. slot[0] therefore empties within MAX_LAT cycles.
- A divider acknowledge and a new issue in the same cycle are legal. A new DIV may be accepted in the cycle its predecessor is acked.
- Flush (flush_i = 1):
  - All slots clear and div_busy clears on the next edge.
  - wb_valid_o, div_ack_o and unit_start_o are forced to 0 in the flush cycle.
  - div_kill_o = flush_i & div_busy, for one cycle.
  - A div_done_i arriving in the flush cycle is not acked; the kill discards it.
- Reset: all slots invalid, div_busy = 0, stored tag = 0. Every output is 0 during and after reset until stimulus arrives.
- Reset in mid-operation discards all reservations; no wb_valid_o is produced afterwards.

Decomposition:
- Add to floating_point_unit_pkg:
  - typedef enum logic [2:0] fpu_unit_t: ADD=0, MUL=1, CVT=2, CMP=3, DIV=4.
  - Packed struct fpu_slot_t {valid, unit, tag}.
- Sub-module fpu_result_reservation: the shift table with its conflict-check and write ports.
- The scheduler holds the divider tracking, arbitration and flush logic.

Test Plan:
- Latency per unit:
  - ADD with tag 5 accepted at cycle 10 -> wb_valid_o at cycle 13, wb_unit_o = ADD, wb_tag_o = 5.
  - Same check for MUL, CVT and CMP at 4, 2 and 1 cycles.
- Collision stall:
  - MUL accepted at cycle 0, CVT offered at cycle 2 -> issue_ready_o = 0 at cycle 2, CVT accepted at cycle 3, writebacks at cycles 4 and 5.
- Back-to-back:
  - ADD every cycle for 8 cycles -> all accepted, 8 consecutive writebacks with tags in order.
- Divider arbitration:
  - DIV tag 9 issued, then ADD stream, div_done_i raised while slot[0] is busy -> issue_ready_o = 0 until drained.
  - Then wb_unit_o = DIV, wb_tag_o = 9, div_ack_o = 1 in the same cycle; a second DIV is refused while busy.
- Flush:
  - ADD, MUL and DIV in flight, flush_i pulsed -> div_kill_o = 1 for one cycle, no further wb_valid_o, next issue accepted the cycle after.
- Reset:
  - rst_i asserted with 3 reservations pending -> all outputs 0, no writebacks after release.

Source files
------------

// File: rtl/floating_point_unit_pkg.sv
// Shared types for the FPU issue/writeback scheduler: unit encoding and
// result-bus reservation slot.
package floating_point_unit_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    MUL = 3'd1,
    CVT = 3'd2,
    CMP = 3'd3,
    DIV = 3'd4
  } fpu_unit_t;

  localparam int FPU_UNITS = 5;
  // Tag width carried in a reservation slot; the scheduler's TAG_W must match.
  localparam int FPU_TAG_W = 6;

  typedef struct packed {
    logic                 valid;
    fpu_unit_t            unit;
    logic [FPU_TAG_W-1:0] tag;
  } fpu_slot_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/fpu_result_reservation.sv
// Shifting reservation table for the shared result bus. Slot 0 is the
// writeback happening this cycle; slot i writes back i cycles from now.
module fpu_result_reservation
  import floating_point_unit_pkg::*;
#(
  parameter int MAX_LAT = 4,
  parameter int LAT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [LAT_W-1:0] query_lat,
  output logic             query_free,
  input  logic             wr_en,
  input  logic [LAT_W-1:0] wr_lat,
  input  fpu_slot_t        wr_slot,
  output fpu_slot_t        head
);

  fpu_slot_t slot     [MAX_LAT];
  fpu_slot_t slot_nxt [MAX_LAT];

  // A latency-L op lands in slot L-1 after the shift, which is where slot L
  // is heading, so slot L is the one that must be empty.
  always_comb begin
    query_free = 1'b0;
    if (query_lat == LAT_W'(MAX_LAT)) begin
      query_free = 1'b1;
    end else begin
      for (int i = 0; i < MAX_LAT; i++) begin
        if (query_lat == LAT_W'(i)) query_free = !slot[i].valid;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_LAT - 1; i++) slot_nxt[i] = slot[i+1];
    slot_nxt[MAX_LAT-1] = '0;
    if (wr_en) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        if (wr_lat == LAT_W'(i + 1)) slot_nxt[i] = wr_slot;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAT; i++) slot[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < MAX_LAT; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_LAT; i++) slot[i] <= slot_nxt[i];
    end
  end

  assign head = slot[0];

endmodule

// File: rtl/floating_point_unit_scheduler.sv
// FPU issue and writeback scheduler: starts sub-units, reserves the shared
// result bus, tracks the iterative divider and handles flush.
module floating_point_unit_scheduler
  import floating_point_unit_pkg::*;
#(
  parameter int TAG_W   = FPU_TAG_W,
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 4,
  parameter int CVT_LAT = 2,
  parameter int CMP_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             issue_valid_i,
  input  logic [2:0]       issue_unit_i,
  input  logic [TAG_W-1:0] issue_tag_i,
  output logic             issue_ready_o,
  output logic [4:0]       unit_start_o,
  input  logic             div_done_i,
  output logic             div_ack_o,
  output logic             div_kill_o,
  output logic             wb_valid_o,
  output logic [2:0]       wb_unit_o,
  output logic [TAG_W-1:0] wb_tag_o
);

  localparam int MAX_LAT = max4(ADD_LAT, MUL_LAT, CVT_LAT, CMP_LAT);
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  logic             div_busy;
  logic [TAG_W-1:0] div_tag;
  logic [LAT_W-1:0] lat_sel;
  logic             is_fixed;
  logic             is_div;
  logic             slot_free;
  logic             div_free;
  logic             unit_free;
  logic             accept;
  fpu_slot_t        wr_slot;
  fpu_slot_t        head;

  always_comb begin
    lat_sel  = '0;
    is_fixed = 1'b0;
    is_div   = 1'b0;
    case (issue_unit_i)
      ADD: begin lat_sel = LAT_W'(ADD_LAT); is_fixed = 1'b1; end
      MUL: begin lat_sel = LAT_W'(MUL_LAT); is_fixed = 1'b1; end
      CVT: begin lat_sel = LAT_W'(CVT_LAT); is_fixed = 1'b1; end
      CMP: begin lat_sel = LAT_W'(CMP_LAT); is_fixed = 1'b1; end
      DIV: is_div = 1'b1;
      default: ;
    endcase
  end

  fpu_result_reservation #(
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_resv (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (flush_i),
    .query_lat  (lat_sel),
    .query_free (slot_free),
    .wr_en      (accept & is_fixed),
    .wr_lat     (lat_sel),
    .wr_slot    (wr_slot),
    .head       (head)
  );

  always_comb begin
    wr_slot       = '0;
    wr_slot.valid = 1'b1;
    wr_slot.unit  = fpu_unit_t'(issue_unit_i);
    wr_slot.tag   = issue_tag_i;
  end

  // Divider only gets the bus when no fixed-latency result is due.
  assign div_ack_o = ~rst_i & ~flush_i & div_done_i & ~head.valid;
  assign div_free  = ~div_busy | div_ack_o;
  assign unit_free = (is_fixed & slot_free) | (is_div & div_free);

  // Holding off issue while a divider result waits lets slot 0 drain.
  assign issue_ready_o = ~rst_i & ~flush_i & unit_free & (~div_done_i | div_ack_o);
  assign accept        = issue_valid_i & issue_ready_o;

  always_comb begin
    unit_start_o = '0;
    if (accept) unit_start_o[issue_unit_i] = 1'b1;
  end

  always_comb begin
    wb_valid_o = 1'b0;
    wb_unit_o  = '0;
    wb_tag_o   = '0;
    if (!rst_i && !flush_i) begin
      if (head.valid) begin
        wb_valid_o = 1'b1;
        wb_unit_o  = head.unit;
        wb_tag_o   = head.tag;
      end else if (div_ack_o) begin
        wb_valid_o = 1'b1;
        wb_unit_o  = DIV;
        wb_tag_o   = div_tag;
      end
    end
  end

  assign div_kill_o = flush_i & div_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_busy <= 1'b0;
      div_tag  <= '0;
    end else if (flush_i) begin
      div_busy <= 1'b0;
    end else if (accept && is_div) begin
      div_busy <= 1'b1;
      div_tag  <= issue_tag_i;
    end else if (div_ack_o) begin
      div_busy <= 1'b0;
    end
  end

endmodule
